// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the HI/LO multiply/divide unit:
//               operation encodings, FSM state encoding, default width.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Default operand width (HI and LO are each this wide)
    localparam int MD_WIDTH = 32;

    // Operation codes presented on md_op
    typedef enum logic [2:0] {
        MD_MULTU = 3'd0,
        MD_MULT  = 3'd1,
        MD_DIVU  = 3'd2,
        MD_DIV   = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_hilo_div_step.sv
`default_nettype none
// ============================================================================
// Module      : md_div_step
// Description : One combinational restoring-division iteration. The pair
//               {rem_i, quo_i} is shifted left one bit; the divisor is
//               subtracted from the widened remainder and the difference is
//               kept only when it does not go negative. The dividend bits
//               enter from the top of quo_i while quotient bits fill the
//               bottom.
// Revision    : 1.0 - initial release
// ============================================================================
module md_div_step
#(
    parameter int WIDTH = 32
)
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // Trial subtraction; the partial remainder stays below the divisor, so
    // a successful difference always fits back into WIDTH bits.
    always_comb begin
        w_shifted = {rem_i, quo_i[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, div_i};
        if (w_trial[WIDTH]) begin
            rem_o = w_shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = w_trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_hilo
// Description : Multi-cycle multiply/divide unit owning the HI/LO registers.
//               Radix-2 shift-add multiply and restoring divide on operand
//               magnitudes, followed by one sign-fix/commit cycle.
//               Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU use a
//               single-cycle multiplier and never raise md_busy.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             md_cancel,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int             CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic             neg_q;      // product / quotient must be negated
    logic             rem_neg_q;  // remainder takes the dividend's sign
    logic [WIDTH-1:0] opnd_q;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi_q;   // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_q;   // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] acc_hi_d;
    logic [WIDTH-1:0] acc_lo_d;

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand sign split at issue: signed ops work on magnitudes
    always_comb begin
        op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
        a_neg     = op_signed & md_a[WIDTH-1];
        b_neg     = op_signed & md_b[WIDTH-1];
        a_mag     = a_neg ? (~md_a + 1'b1) : md_a;
        b_mag     = b_neg ? (~md_b + 1'b1) : md_b;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag;
    logic [2*WIDTH-1:0] fast_prod;

    // Single-cycle full-width product, sign applied to the magnitude product
    always_comb begin
        fast_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
        fast_prod = (a_neg ^ b_neg) ? (~fast_mag + 1'b1) : fast_mag;
    end
`endif

    md_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i (acc_hi_q),
        .quo_i (acc_lo_q),
        .div_i (opnd_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );

    // One radix-2 iteration: shift-add multiply or restoring divide
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        if (is_div_q) begin
            acc_hi_d = div_rem;
            acc_lo_d = div_quo;
        end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the finished magnitudes; a zero divisor yields an
    // all-ones quotient while the remainder path naturally returns md_a.
    always_comb begin
        prod_mag = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? (~prod_mag + 1'b1) : prod_mag;
        quo_fix  = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_fix  = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        if (opnd_q == '0) begin
            quo_fix = '1;
        end
    end

    // Sequencer, iteration registers and architectural HI/LO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (md_start && !md_cancel) begin
                        case (md_op)
                            MD_MTHI: hi_q <= md_a;
                            MD_MTLO: lo_q <= md_a;
                            MD_MULTU, MD_MULT: begin
`ifdef MULDIV_FAST_MUL_EN
                                hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
                                lo_q   <= fast_prod[WIDTH-1:0];
                                done_q <= 1'b1;
`else
                                state_q   <= RUN;
                                cnt_q     <= '0;
                                is_div_q  <= 1'b0;
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= 1'b0;
                                opnd_q    <= a_mag;
                                acc_hi_q  <= '0;
                                acc_lo_q  <= b_mag;
                                busy_q    <= 1'b1;
`endif
                            end
                            MD_DIVU, MD_DIV: begin
                                state_q   <= RUN;
                                cnt_q     <= '0;
                                is_div_q  <= 1'b1;
                                neg_q     <= a_neg ^ b_neg;
                                rem_neg_q <= a_neg;
                                opnd_q    <= b_mag;
                                acc_hi_q  <= '0;
                                acc_lo_q  <= a_mag;
                                busy_q    <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (md_cancel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_hi_q <= acc_hi_d;
                        acc_lo_q <= acc_lo_d;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!md_cancel) begin
                        done_q <= 1'b1;
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;
    assign hi_out  = hi_q;
    assign lo_out  = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_hilo
// Description : Self-checking bench for muldiv_hilo: directed vector table
//               plus handshake, cancel and reset sequences.
//               Honours MULDIV_FAST_MUL_EN when the build defines it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int NV = 13;

    logic        clk;
    logic        rst;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_cancel;
    logic        md_busy;
    logic        md_done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [NV];

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_a      (md_a),
        .md_b      (md_b),
        .md_cancel (md_cancel),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hung run, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation and watch 40 cycles from the cycle after the accept
    // edge. Optional one-cycle start injection / cancel at a given cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input int cancel_at,
                          output int busy_cnt, output int done_cnt,
                          output logic [31:0] hi_r, output logic [31:0] lo_r, output int bad);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        bit          seen;
        busy_cnt = 0;
        done_cnt = 0;
        bad      = 0;
        seen     = 1'b0;
        hi_r     = '0;
        lo_r     = '0;
        @(negedge clk);
        prev_hi  = hi_out;
        prev_lo  = lo_out;
        md_start = 1'b1;
        md_op    = op;
        md_a     = a;
        md_b     = b;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            md_start  = 1'b0;
            md_cancel = 1'b0;
            if (md_busy) busy_cnt++;
            if (md_done) begin
                done_cnt++;
                if (md_busy) bad++;
                if (!seen) begin
                    hi_r = hi_out;
                    lo_r = lo_out;
                    seen = 1'b1;
                end
            end
            if (!seen && (hi_out !== prev_hi || lo_out !== prev_lo)) bad++;
            if (i == inj_at) begin
                md_start = 1'b1;
                md_op    = MD_DIVU;
                md_a     = 32'd9;
                md_b     = 32'd3;
            end
            if (i == cancel_at) md_cancel = 1'b1;
            @(negedge clk);
        end
        md_start  = 1'b0;
        md_cancel = 1'b0;
        if (!seen) begin
            hi_r = hi_out;
            lo_r = lo_out;
        end
    endtask

    initial begin
        int          bc;
        int          dc;
        int          bad;
        int          exp_busy;
        logic [31:0] h;
        logic [31:0] l;
        logic [31:0] ph;
        logic [31:0] pl;
        logic [2:0]  seq_op;

        vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{MD_DIVU,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{MD_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};
        vecs[7]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[9]  = '{MD_MULT,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0,        32'd6};
        vecs[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        vecs[12] = '{MD_MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780};

        rst       = 1'b1;
        md_start  = 1'b0;
        md_op     = '0;
        md_a      = '0;
        md_b      = '0;
        md_cancel = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_hi",   {32'd0, hi_out}, 64'd0);
        chk("reset_lo",   {32'd0, lo_out}, 64'd0);
        chk("reset_busy", {63'd0, md_busy}, 64'd0);
        chk("reset_done", {63'd0, md_done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MTHI then MTLO on consecutive cycles
        md_start = 1'b1;
        md_op    = MD_MTHI;
        md_a     = 32'hA5A5A5A5;
        @(negedge clk);
        chk("mthi_hi",   {32'd0, hi_out}, {32'd0, 32'hA5A5A5A5});
        chk("mthi_busy", {63'd0, md_busy}, 64'd0);
        md_op = MD_MTLO;
        md_a  = 32'h5A5A5A5A;
        @(negedge clk);
        md_start = 1'b0;
        chk("mtlo_lo",   {32'd0, lo_out}, {32'd0, 32'h5A5A5A5A});
        chk("mtlo_hi",   {32'd0, hi_out}, {32'd0, 32'hA5A5A5A5});
        chk("mtlo_busy", {63'd0, md_busy}, 64'd0);
        chk("mtlo_done", {63'd0, md_done}, 64'd0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, -1, bc, dc, h, l, bad);
            exp_busy = (FAST && (vecs[i].op == MD_MULTU || vecs[i].op == MD_MULT)) ? 0 : 33;
            chk($sformatf("vec%0d_hi", i),    {32'd0, h}, {32'd0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i),    {32'd0, l}, {32'd0, vecs[i].lo});
            chk($sformatf("vec%0d_busy", i),  64'(bc), 64'(exp_busy));
            chk($sformatf("vec%0d_done", i),  64'(dc), 64'd1);
            chk($sformatf("vec%0d_clean", i), 64'(bad), 64'd0);
        end

        // Second start while busy is ignored
        seq_op = FAST ? 3'(MD_DIVU) : 3'(MD_MULTU);
        run_op(seq_op, 32'd100, 32'd7, 5, -1, bc, dc, h, l, bad);
        chk("ign_hi",    {32'd0, h}, FAST ? 64'd2 : 64'd0);
        chk("ign_lo",    {32'd0, l}, FAST ? 64'd14 : 64'd700);
        chk("ign_busy",  64'(bc), 64'd33);
        chk("ign_done",  64'(dc), 64'd1);
        chk("ign_clean", 64'(bad), 64'd0);
        chk("ign_after_lo", {32'd0, lo_out}, FAST ? 64'd14 : 64'd700);

        // Cancel at cycle 10
        ph = hi_out;
        pl = lo_out;
        run_op(seq_op, 32'd12345, 32'd99, -1, 10, bc, dc, h, l, bad);
        chk("cancel_hi",   {32'd0, h}, {32'd0, ph});
        chk("cancel_lo",   {32'd0, l}, {32'd0, pl});
        chk("cancel_busy", 64'(bc), 64'd11);
        chk("cancel_done", 64'(dc), 64'd0);
        chk("cancel_clean", 64'(bad), 64'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        md_start = 1'b1;
        md_op    = MD_DIVU;
        md_a     = 32'd1000;
        md_b     = 32'd3;
        @(negedge clk);
        md_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstmid_busy_before", {63'd0, md_busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_hi",   {32'd0, hi_out}, 64'd0);
        chk("rstmid_lo",   {32'd0, lo_out}, 64'd0);
        chk("rstmid_busy", {63'd0, md_busy}, 64'd0);
        chk("rstmid_done", {63'd0, md_done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_done) dc++;
            if (md_busy) bc++;
        end
        chk("rstmid_no_done", 64'(dc), 64'd0);
        chk("rstmid_no_busy", 64'(bc), 64'd0);
        chk("rstmid_lo_kept", {32'd0, lo_out}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
